calc_sequencer: RTL and testbench
=================================

# calc_sequencer

Keypad-driven sequencer for the 3-digit signed-BCD add/subtract datapath. It collects digit entry, tracks a signed accumulator and pending operator, and drives operands into an external instance of the arithmetic unit. It captures that unit's result one cycle later and presents display data. It sits between the keypad decoder and the 7-segment display driver.

## Interface
- Parameters: none. Widths are fixed by the 3-digit BCD datapath.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- key_valid  in  1  one-cycle key strobe
- key_code  in  4  0–9 digit; 10 MINUS; 11 PLUS; 12 EQUALS; 13 CLEAR; 14–15 ignored
- key_ready  out  1  key accepted when key_valid && key_ready; otherwise dropped
- alu_sign  out  4  registered sign operand: 0 = A−B, 10 = −(A+B)
- alu_num  out  12  registered BCD magnitude A (accumulator)
- alu_sub  out  12  registered BCD magnitude B (entry)
- alu_res  in  16  {sign nibble 0/10, 3 BCD digits}, combinational from alu_* outputs
- disp  out  16  {sign nibble, 3 BCD digits} for the display
- done  out  1  one-cycle pulse when the accumulator is updated
- err  out  1  sticky overflow flag

## Operation
- State: acc_sign (0/10), acc_mag[11:0], entry[11:0], ndig (0–3), pend_op ∈ {LOAD, PLUS, MINUS}, fsm ∈ {ENTRY, EXEC, SHOW}.
- Digit key (ENTRY):
  - if ndig<3: entry = {entry[7:0], d}, ndig++.
  - 4th and later digits are consumed and ignored.
- Digit key (SHOW): entry = {8'h0, d}, ndig = 1, go to ENTRY.
- Operator or EQUALS with ndig>0 (fresh entry):
  - load alu_* per the mapping below; go to EXEC.
  - new pend_op = the operator, or LOAD for EQUALS.
- Operator with ndig=0: replace pend_op only, no calculation; go to ENTRY.
- EQUALS with ndig=0: ignored.
- Mapping (A = acc_mag, B = entry):
  - LOAD: no ALU use. acc = {0, B} captured in EXEC.
  - PLUS, acc +: alu (10,A,B), flip result sign; overflow check.
  - PLUS, acc −: alu (0,A,B), flip result sign.
  - MINUS, acc +: alu (0,A,B), sign as returned.
  - MINUS, acc −: alu (10,A,B), sign as returned; overflow check.
- Overflow check: the block computes a BCD carry-out of A+B.
  - If A+B > 999: acc = {0, 12'h999}, err=1. The ALU result is discarded.
  - The ALU's own saturation does not cover 1000–1023, so this check is mandatory.
- Normalize: magnitude 12'h000 always yields sign 0 (no −0).
- EXEC, one cycle: capture into acc, clear entry and ndig, pulse done, go to SHOW.
- CLEAR (any accepted cycle): same effect as reset.
- err stays set until CLEAR or rst. Later operations still execute.
- disp:
  - ENTRY with ndig>0: {0, entry}.
  - ENTRY with ndig=0, and SHOW: {acc_sign, acc_mag}.
  - EXEC: holds its previous value.

## Timing
- Reset values:
  - fsm=ENTRY, acc=0 positive, entry=0, ndig=0, pend_op=LOAD.
  - alu_sign/num/sub=0, disp=16'h0000, key_ready=1, done=0, err=0.
- Operand load:
  - Key accepted at edge E0 → alu_* valid after E0.
  - alu_res is sampled at E1 → acc, disp and done are valid after E1.
  - Latency is 1 cycle. done is high for the cycle after E1.
- key_ready=0 only while fsm=EXEC. key_valid in EXEC is dropped, not queued.
- rst asserted during EXEC: reset wins and no capture occurs.
- CLEAR and rst are identical in effect. CLEAR cannot occur in EXEC.

## Structure
- Package calc_pkg:
  - key codes KEY_MINUS=10, KEY_PLUS=11, KEY_EQ=12, KEY_CLR=13
  - SIGN_POS=4'd0, SIGN_NEG=4'd10, BCD_MAX=12'h999
  - op and fsm enums
- Sub-module bcd3_carry: 3-digit BCD adder carry-out (A+B>999) for the overflow check.
- The arithmetic datapath is instantiated beside this block, not inside it.

## Test plan
- Keys 1,2,3,PLUS,4,5,6,EQ → disp=16'h0579, done pulse, err=0.
- Keys 1,0,0,MINUS,2,5,0,EQ → disp=16'hA150. Then PLUS,1,5,0,EQ → disp=16'h0000 (sign 0, not A000).
- Keys 9,9,9,PLUS,1,EQ → disp=16'h0999, err=1. Then 5,EQ → disp=16'h0005, err still 1. CLEAR → err=0.
- Keys 1,2,3,4,EQ → disp=16'h0123. Then MINUS,PLUS,2,EQ → disp=16'h0125.
- key_valid held during EXEC → that key is dropped, key_ready=0 for exactly 1 cycle.
- rst pulsed in the EXEC cycle → all outputs at reset values next cycle, no done pulse.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared key codes, sign nibbles and enums for the BCD calculator
// sequencer. The sign-flip helper is used when capturing ALU results.
package calc_pkg;

    localparam logic [3:0]  KEY_MINUS = 4'd10;
    localparam logic [3:0]  KEY_PLUS  = 4'd11;
    localparam logic [3:0]  KEY_EQ    = 4'd12;
    localparam logic [3:0]  KEY_CLR   = 4'd13;

    localparam logic [3:0]  SIGN_POS  = 4'd0;
    localparam logic [3:0]  SIGN_NEG  = 4'd10;
    localparam logic [11:0] BCD_MAX   = 12'h999;

    typedef enum logic [1:0] {
        OP_LOAD,
        OP_PLUS,
        OP_MINUS
    } op_e;

    typedef enum logic [1:0] {
        ST_ENTRY,
        ST_EXEC,
        ST_SHOW
    } fsm_e;

    function automatic logic [3:0] flip_sign(input logic [3:0] s);
        return (s == SIGN_NEG) ? SIGN_POS : SIGN_NEG;
    endfunction

endpackage

// File: rtl/calc_sequencer_bcd3_carry.sv
// bcd3_carry: carry-out of a 3-digit BCD addition, i.e. (a + b) > 999.
// Ports: a, b = 3-digit BCD magnitudes; cout = 1 when the sum needs 4 digits.
module bcd3_carry (
    input  logic [11:0] a,
    input  logic [11:0] b,
    output logic        cout
);

    logic [4:0] sum;
    logic       c;

    always_comb begin
        sum = 5'd0;
        c   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sum = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, c};
            c   = (sum > 5'd9);
        end
        cout = c;
    end

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad sequencer around an external 3-digit signed-BCD ALU.
// Ports: clk/rst; key_valid/key_code/key_ready key input; alu_sign/alu_num/
// alu_sub registered ALU operands, alu_res ALU result; disp display word;
// done accumulator-update pulse; err sticky overflow.
module calc_sequencer
    import calc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        key_ready,
    output logic [3:0]  alu_sign,
    output logic [11:0] alu_num,
    output logic [11:0] alu_sub,
    input  logic [15:0] alu_res,
    output logic [15:0] disp,
    output logic        done,
    output logic        err
);

    fsm_e        fsm_q, fsm_d;
    op_e         pend_op_q, pend_op_d;
    op_e         exec_op_q, exec_op_d;
    logic [3:0]  acc_sign_q, acc_sign_d;
    logic [11:0] acc_mag_q, acc_mag_d;
    logic [11:0] entry_q, entry_d;
    logic [1:0]  ndig_q, ndig_d;
    logic [3:0]  alu_sign_q, alu_sign_d;
    logic [11:0] alu_num_q, alu_num_d;
    logic [11:0] alu_sub_q, alu_sub_d;
    logic [15:0] disp_q, disp_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        carry;
    logic [3:0]  res_sign;
    op_e         key_op;

    // Magnitudes only overflow when the ALU is asked for -(A+B).
    bcd3_carry u_carry (
        .a    (alu_num_q),
        .b    (alu_sub_q),
        .cout (carry)
    );

    always_comb begin
        fsm_d      = fsm_q;
        pend_op_d  = pend_op_q;
        exec_op_d  = exec_op_q;
        acc_sign_d = acc_sign_q;
        acc_mag_d  = acc_mag_q;
        entry_d    = entry_q;
        ndig_d     = ndig_q;
        alu_sign_d = alu_sign_q;
        alu_num_d  = alu_num_q;
        alu_sub_d  = alu_sub_q;
        done_d     = 1'b0;
        err_d      = err_q;
        res_sign   = SIGN_POS;
        key_op     = OP_LOAD;

        case (key_code)
            KEY_PLUS:  key_op = OP_PLUS;
            KEY_MINUS: key_op = OP_MINUS;
            default:   key_op = OP_LOAD;
        endcase

        if (fsm_q == ST_EXEC) begin
            if (exec_op_q == OP_LOAD) begin
                acc_sign_d = SIGN_POS;
                acc_mag_d  = entry_q;
            end else if (alu_sign_q == SIGN_NEG && carry) begin
                acc_sign_d = SIGN_POS;
                acc_mag_d  = BCD_MAX;
                err_d      = 1'b1;
            end else begin
                res_sign = alu_res[15:12];
                if (exec_op_q == OP_PLUS) begin
                    res_sign = flip_sign(res_sign);
                end
                if (alu_res[11:0] == 12'h000) begin
                    res_sign = SIGN_POS;
                end
                acc_sign_d = res_sign;
                acc_mag_d  = alu_res[11:0];
            end
            entry_d = 12'h000;
            ndig_d  = 2'd0;
            done_d  = 1'b1;
            fsm_d   = ST_SHOW;
        end else if (key_valid) begin
            if (key_code == KEY_CLR) begin
                fsm_d      = ST_ENTRY;
                pend_op_d  = OP_LOAD;
                exec_op_d  = OP_LOAD;
                acc_sign_d = SIGN_POS;
                acc_mag_d  = 12'h000;
                entry_d    = 12'h000;
                ndig_d     = 2'd0;
                alu_sign_d = SIGN_POS;
                alu_num_d  = 12'h000;
                alu_sub_d  = 12'h000;
                err_d      = 1'b0;
            end else if (key_code <= 4'd9) begin
                // Entry is already cleared in SHOW, so shifting in
                // the digit there yields {8'h0, d}.
                if (ndig_q < 2'd3) begin
                    entry_d = {entry_q[7:0], key_code};
                    ndig_d  = ndig_q + 2'd1;
                end
                fsm_d = ST_ENTRY;
            end else if (key_code == KEY_PLUS || key_code == KEY_MINUS ||
                         key_code == KEY_EQ) begin
                if (ndig_q != 2'd0) begin
                    exec_op_d = pend_op_q;
                    pend_op_d = key_op;
                    if (pend_op_q != OP_LOAD) begin
                        // Plus on a positive acc, or minus on a negative
                        // one, adds magnitudes: ask for -(A+B).
                        alu_sign_d = ((pend_op_q == OP_PLUS) ^
                                      (acc_sign_q == SIGN_NEG))
                                     ? SIGN_NEG : SIGN_POS;
                        alu_num_d  = acc_mag_q;
                        alu_sub_d  = entry_q;
                    end
                    fsm_d = ST_EXEC;
                end else if (key_code != KEY_EQ) begin
                    pend_op_d = key_op;
                    fsm_d     = ST_ENTRY;
                end
            end
        end

        if (fsm_d == ST_EXEC) begin
            disp_d = disp_q;
        end else if (fsm_d == ST_ENTRY && ndig_d != 2'd0) begin
            disp_d = {SIGN_POS, entry_d};
        end else begin
            disp_d = {acc_sign_d, acc_mag_d};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q      <= ST_ENTRY;
            pend_op_q  <= OP_LOAD;
            exec_op_q  <= OP_LOAD;
            acc_sign_q <= SIGN_POS;
            acc_mag_q  <= 12'h000;
            entry_q    <= 12'h000;
            ndig_q     <= 2'd0;
            alu_sign_q <= SIGN_POS;
            alu_num_q  <= 12'h000;
            alu_sub_q  <= 12'h000;
            disp_q     <= 16'h0000;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            pend_op_q  <= pend_op_d;
            exec_op_q  <= exec_op_d;
            acc_sign_q <= acc_sign_d;
            acc_mag_q  <= acc_mag_d;
            entry_q    <= entry_d;
            ndig_q     <= ndig_d;
            alu_sign_q <= alu_sign_d;
            alu_num_q  <= alu_num_d;
            alu_sub_q  <= alu_sub_d;
            disp_q     <= disp_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign key_ready = (fsm_q != ST_EXEC);
    assign alu_sign  = alu_sign_q;
    assign alu_num   = alu_num_q;
    assign alu_sub   = alu_sub_q;
    assign disp      = disp_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: table vectors, hand-written EXEC corner cases and
// random keys checked against an integer-arithmetic calculator model.
module tb_calc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        key_ready;
    logic [3:0]  alu_sign;
    logic [11:0] alu_num;
    logic [11:0] alu_sub;
    logic [15:0] alu_res;
    logic [15:0] disp;
    logic        done;
    logic        err;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [3:0]  key;
        logic        chk;
        logic [15:0] disp;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    // Calculator model: plain signed integers.
    int m_acc;
    int m_entry;
    int m_n;
    int m_op;
    bit m_err;

    calc_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .alu_sign  (alu_sign),
        .alu_num   (alu_num),
        .alu_sub   (alu_sub),
        .alu_res   (alu_res),
        .disp      (disp),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic int b2i(input logic [11:0] v);
        return v[11:8] * 100 + v[7:4] * 10 + v[3:0];
    endfunction

    function automatic logic [11:0] i2b(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    // External ALU: 0 -> A-B, 10 -> -(A+B), saturating at 999.
    function automatic logic [15:0] alu_f(input logic [3:0] s,
                                          input logic [11:0] a,
                                          input logic [11:0] b);
        int r;
        if (s == 4'd10) begin
            r = b2i(a) + b2i(b);
            if (r > 999) r = 999;
            return {4'hA, i2b(r)};
        end
        r = b2i(a) - b2i(b);
        if (r < 0) return {4'hA, i2b(-r)};
        return {4'h0, i2b(r)};
    endfunction

    assign alu_res = alu_f(alu_sign, alu_num, alu_sub);

    task automatic m_reset();
        m_acc = 0; m_entry = 0; m_n = 0; m_op = 0; m_err = 0;
    endtask

    task automatic model_key(input logic [3:0] k, output bit calc);
        int r;
        calc = 0;
        if (k == 4'd13) begin
            m_reset();
        end else if (k <= 4'd9) begin
            if (m_n < 3) begin
                m_entry = m_entry * 10 + int'(k);
                m_n++;
            end
        end else if (k >= 4'd10 && k <= 4'd12) begin
            if (m_n > 0) begin
                calc = 1;
                if (m_op == 1) r = m_acc + m_entry;
                else if (m_op == 2) r = m_acc - m_entry;
                else r = m_entry;
                if (r > 999 || r < -999) begin
                    r = 999;
                    m_err = 1;
                end
                m_acc = r;
                m_entry = 0;
                m_n = 0;
                m_op = (k == 4'd11) ? 1 : (k == 4'd10) ? 2 : 0;
            end else if (k != 4'd12) begin
                m_op = (k == 4'd11) ? 1 : 2;
            end
        end
    endtask

    function automatic logic [15:0] m_disp();
        if (m_n > 0) return {4'h0, i2b(m_entry)};
        if (m_acc < 0) return {4'hA, i2b(-m_acc)};
        return {4'h0, i2b(m_acc)};
    endfunction

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        bit calc;
        model_key(k, calc);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
        chk("key_ready_exec", 16'(key_ready), 16'(!calc));
        chk("done_early", 16'(done), 16'h0);
        @(negedge clk);
        chk("done", 16'(done), 16'(calc));
        chk("disp", disp, m_disp());
        chk("err", 16'(err), 16'(m_err));
        chk("key_ready", 16'(key_ready), 16'h1);
    endtask

    task automatic t(input logic [3:0] k);
        vec_t v;
        v.key = k; v.chk = 1'b0; v.disp = 16'h0; v.err = 1'b0;
        tbl.push_back(v);
    endtask

    task automatic tc(input logic [3:0] k, input logic [15:0] d,
                      input logic e);
        vec_t v;
        v.key = k; v.chk = 1'b1; v.disp = d; v.err = e;
        tbl.push_back(v);
    endtask

    initial begin
        bit calc;
        int r;
        m_reset();

        // 1,2,3 + 4,5,6 =
        t(1); t(2); t(3); t(11); t(4); t(5); t(6); tc(12, 16'h0579, 0);
        tc(13, 16'h0000, 0);
        // 100 - 250 = -150, then + 150 = 0 (no -0)
        t(1); t(0); t(0); t(10); t(2); t(5); t(0); tc(12, 16'hA150, 0);
        t(11); t(1); t(5); t(0); tc(12, 16'h0000, 0);
        tc(13, 16'h0000, 0);
        // 999 + 1 overflows; error sticks until CLEAR
        t(9); t(9); t(9); t(11); t(1); tc(12, 16'h0999, 1);
        t(5); tc(12, 16'h0005, 1);
        tc(13, 16'h0000, 0);
        // 4th digit dropped; operator replacement
        t(1); t(2); t(3); t(4); tc(12, 16'h0123, 0);
        t(10); t(11); t(2); tc(12, 16'h0125, 0);
        tc(12, 16'h0125, 0);
        tc(4'd14, 16'h0125, 0);
        // -499 - 600 overflows to +999
        t(13); t(1); t(10); t(5); t(0); t(0); tc(10, 16'hA499, 0);
        t(6); t(0); t(0); tc(12, 16'h0999, 1);
        // 500 + 499 = 999 exactly, no overflow
        t(13); t(5); t(0); t(0); t(11); t(4); t(9); t(9);
        tc(12, 16'h0999, 0);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_disp", disp, 16'h0000);
        chk("rst_done", 16'(done), 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        chk("rst_ready", 16'(key_ready), 16'h1);
        chk("rst_alu", {alu_sign, alu_num}, 16'h0000);
        chk("rst_alu_sub", 16'(alu_sub), 16'h0000);

        foreach (tbl[i]) begin
            press(tbl[i].key);
            if (tbl[i].chk) begin
                chk($sformatf("tbl%0d_disp", i), disp, tbl[i].disp);
                chk($sformatf("tbl%0d_err", i), 16'(err),
                    16'(tbl[i].err));
            end
        end

        // Key held through EXEC is dropped.
        press(13);
        press(4);
        model_key(12, calc);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'd12;
        @(negedge clk);
        key_code  = 4'd7;
        chk("hold_ready0", 16'(key_ready), 16'h0);
        @(negedge clk);
        key_valid = 1'b0;
        chk("hold_ready1", 16'(key_ready), 16'h1);
        chk("hold_done", 16'(done), 16'h1);
        chk("hold_disp", disp, 16'h0004);
        @(negedge clk);
        chk("hold_dropped", disp, m_disp());
        chk("hold_done_off", 16'(done), 16'h0);

        // Reset during EXEC wins.
        press(9); press(9); press(9); press(11); press(9); press(12);
        press(5);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'd12;
        @(negedge clk);
        key_valid = 1'b0;
        rst = 1'b1;
        chk("rx_ready0", 16'(key_ready), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        chk("rx_disp", disp, 16'h0000);
        chk("rx_done", 16'(done), 16'h0);
        chk("rx_err", 16'(err), 16'h0);
        chk("rx_ready", 16'(key_ready), 16'h1);
        chk("rx_alu", {alu_sign, alu_num}, 16'h0000);
        chk("rx_alu_sub", 16'(alu_sub), 16'h0000);
        @(negedge clk);
        chk("rx_no_done", 16'(done), 16'h0);

        // Random keys against the model.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55) press(4'($urandom_range(0, 9)));
            else if (r < 66) press(4'd11);
            else if (r < 77) press(4'd10);
            else if (r < 92) press(4'd12);
            else if (r < 96) press(4'd13);
            else press(4'($urandom_range(14, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
